// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: issues ROM reads, captures the 1-cycle-latency data,
// tags opcode/immediate words and buffers them in a small FIFO with valid/ready output.
module instr_prefetch_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     fetch_en,
    input  logic                     jump_valid,
    input  logic [ADDR_W-1:0]        jump_addr,
    output logic [ADDR_W-1:0]        rom_address,
    input  logic [DATA_W-1:0]        rom_q,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_is_imm,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W:0] DEPTH_C = (LVL_W + 1)'(DEPTH);

    typedef enum logic {
        TAG_OPCODE = 1'b0,
        TAG_IMM    = 1'b1
    } tag_state_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    tag_state_t        tag_q, tag_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              last_imm_q, last_imm_d;

    logic [LVL_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic              push_imm;
    logic              fifo_nonempty;

    logic [DEPTH-1:0]                 wr_en;
    logic [DEPTH-1:0][DATA_W-1:0]     entry_data;
    logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr;
    logic [DEPTH-1:0]                 entry_imm;

    // Storage entries carry no reset: only slots between rd and wr pointers are ever observed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] data_q;
            logic [ADDR_W-1:0] addr_q;
            logic              imm_q;

            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));

            always_ff @(posedge clock) begin
                if (wr_en[gi]) begin
                    data_q <= rom_q;
                    addr_q <= inflight_addr_q;
                    imm_q  <= push_imm;
                end
            end

            assign entry_data[gi] = data_q;
            assign entry_addr[gi] = addr_q;
            assign entry_imm[gi]  = imm_q;
        end
    endgenerate

    // Credit counts the in-flight read so a capture can never overflow the FIFO.
    always_comb begin
        fifo_nonempty = (level_q != '0);
        credit_used   = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
        issue         = fetch_en & ~jump_valid & (credit_used < DEPTH_C);
        push          = inflight_q & ~jump_valid;
        pop           = fifo_nonempty & out_ready & ~jump_valid;
        push_imm      = (tag_q == TAG_IMM);
    end

    always_comb begin
        out_valid   = fifo_nonempty;
        out_data    = fifo_nonempty ? entry_data[rd_ptr_q] : last_data_q;
        out_addr    = fifo_nonempty ? entry_addr[rd_ptr_q] : last_addr_q;
        out_is_imm  = fifo_nonempty ? entry_imm[rd_ptr_q]  : last_imm_q;
        rom_address = pc_q;
        level       = level_q;
    end

    always_comb begin
        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = inflight_addr_q;
        tag_d           = tag_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        last_data_d     = out_data;
        last_addr_d     = out_addr;
        last_imm_d      = out_is_imm;

        if (jump_valid) begin
            pc_d     = jump_addr;
            tag_d    = TAG_OPCODE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (issue) begin
                pc_d            = pc_q + ADDR_W'(1);
                inflight_addr_d = pc_q;
            end

            // An mvi opcode marks the next captured word as its immediate.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                case (tag_q)
                    TAG_OPCODE: tag_d = (rom_q[DATA_W-1:DATA_W-2] == 2'b01) ? TAG_IMM : TAG_OPCODE;
                    TAG_IMM:    tag_d = TAG_OPCODE;
                    default:    tag_d = TAG_OPCODE;
                endcase
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            tag_q           <= TAG_OPCODE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            last_data_q     <= '0;
            last_addr_q     <= '0;
            last_imm_q      <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            tag_q           <= tag_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            last_data_q     <= last_data_d;
            last_addr_q     <= last_addr_d;
            last_imm_q      <= last_imm_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       fetch_en;
    logic       jump_valid;
    logic [4:0] jump_addr;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [7:0] out_data;
    logic       out_is_imm;
    logic [4:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;

    logic [7:0] rom [32];

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] addr;
        logic       imm;
    } ent_t;

    ent_t       q[$];
    ent_t       m_last;
    ent_t       m_ent;
    logic [4:0] m_pc;
    logic       m_inf;
    logic [4:0] m_inf_addr;
    logic       m_tag_imm;
    logic       m_issue;

    instr_prefetch_unit #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .fetch_en    (fetch_en),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .out_data    (out_data),
        .out_is_imm  (out_is_imm),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= rom[rom_address];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched words plus one in-flight read slot.
    task model_step();
        if (!resetn) begin
            q.delete();
            m_pc       = '0;
            m_inf      = 1'b0;
            m_inf_addr = '0;
            m_tag_imm  = 1'b0;
            m_last     = '0;
        end else begin
            if (q.size() != 0) m_last = q[0];
            if (jump_valid) begin
                q.delete();
                m_inf     = 1'b0;
                m_tag_imm = 1'b0;
                m_pc      = jump_addr;
            end else begin
                m_issue = fetch_en && ((q.size() + int'(m_inf)) < DEPTH);
                if (q.size() != 0 && out_ready) begin
                    m_ent = q.pop_front();
                    $display("[TB] pop addr=%0d data=%02h imm=%0d", m_ent.addr, m_ent.data, m_ent.imm);
                end
                if (m_inf) begin
                    m_ent.data = rom[m_inf_addr];
                    m_ent.addr = m_inf_addr;
                    m_ent.imm  = m_tag_imm;
                    m_tag_imm  = m_tag_imm ? 1'b0 : (m_ent.data[7:6] == 2'b01);
                    q.push_back(m_ent);
                end
                m_inf = m_issue;
                if (m_issue) begin
                    m_inf_addr = m_pc;
                    m_pc       = m_pc + 5'd1;
                end
            end
        end
    endtask

    always @(posedge clock or negedge resetn) model_step();

    always @(negedge clock) begin
        if (resetn) begin
            ent_t head;
            logic exp_valid;
            exp_valid = (q.size() != 0);
            head      = exp_valid ? q[0] : m_last;
            check("model_valid", 32'(out_valid), 32'(exp_valid));
            check("model_level", 32'(level), 32'(q.size()));
            check("model_pc",    32'(rom_address), 32'(m_pc));
            check("model_data",  32'(out_data), 32'(head.data));
            check("model_addr",  32'(out_addr), 32'(head.addr));
            check("model_imm",   32'(out_is_imm), 32'(head.imm));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        #2 resetn = 1'b0;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
    endtask

    logic [7:0] t1_data [4];
    logic       t1_imm  [4];

    initial begin
        resetn     = 1'b0;
        fetch_en   = 1'b0;
        jump_valid = 1'b0;
        jump_addr  = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rom[0]  = 8'h08; rom[1] = 8'h50; rom[2] = 8'h2A; rom[3] = 8'h8A;
        rom[31] = 8'h41;
        t1_data = '{8'h08, 8'h50, 8'h2A, 8'h8A};
        t1_imm  = '{1'b0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pc",    32'(rom_address), 32'd0);
        check("rst_data",  32'(out_data), 32'd0);
        check("rst_addr",  32'(out_addr), 32'd0);
        check("rst_imm",   32'(out_is_imm), 32'd0);

        // Streaming from reset release
        fetch_en = 1'b1; out_ready = 1'b1;
        #2 resetn = 1'b1;
        @(negedge clock);
        check("t1_latency_valid", 32'(out_valid), 32'd0);
        check("t1_pc1", 32'(rom_address), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data",  32'(out_data), 32'(t1_data[k]));
            check("t1_addr",  32'(out_addr), 32'(k));
            check("t1_imm",   32'(out_is_imm), 32'(t1_imm[k]));
        end

        // Backpressure fill then drain
        out_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge clock);
        check("t2_level_full", 32'(level), 32'd4);
        check("t2_pc_stall",   32'(rom_address), 32'd4);
        check("t2_head_addr",  32'(out_addr), 32'd0);
        out_ready = 1'b1;
        @(negedge clock);
        check("t2_next_addr", 32'(out_addr), 32'd1);
        check("t2_next_data", 32'(out_data), 32'h50);
        repeat (10) @(negedge clock);

        // PC wrap with mvi at 31
        do_reset();
        jump_valid = 1'b1; jump_addr = 5'd31;
        @(negedge clock);
        jump_valid = 1'b0;
        check("t3_pc31", 32'(rom_address), 32'd31);
        @(negedge clock);
        check("t3_wrap", 32'(rom_address), 32'd0);
        @(negedge clock);
        check("t3_w31_data", 32'(out_data), 32'h41);
        check("t3_w31_addr", 32'(out_addr), 32'd31);
        check("t3_w31_imm",  32'(out_is_imm), 32'd0);
        @(negedge clock);
        check("t3_w0_addr", 32'(out_addr), 32'd0);
        check("t3_w0_imm",  32'(out_is_imm), 32'd1);
        repeat (4) @(negedge clock);

        // Jump while an mvi immediate is in flight
        do_reset();
        jump_valid = 1'b1; jump_addr = 5'd31;
        @(negedge clock);
        jump_valid = 1'b0;
        repeat (2) @(negedge clock);
        jump_valid = 1'b1; jump_addr = 5'd5;
        @(negedge clock);
        jump_valid = 1'b0;
        check("t4m_level", 32'(level), 32'd0);
        check("t4m_pc",    32'(rom_address), 32'd5);
        repeat (2) @(negedge clock);
        check("t4m_valid", 32'(out_valid), 32'd1);
        check("t4m_addr",  32'(out_addr), 32'd5);
        check("t4m_imm",   32'(out_is_imm), 32'd0);

        // Jump with three words held and a read in flight
        out_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clock);
        check("t4_level3", 32'(level), 32'd3);
        jump_valid = 1'b1; jump_addr = 5'd5;
        @(negedge clock);
        jump_valid = 1'b0;
        check("t4_level0", 32'(level), 32'd0);
        check("t4_pc5",    32'(rom_address), 32'd5);
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_addr",  32'(out_addr), 32'd5);
        check("t4_imm",   32'(out_is_imm), 32'd0);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clock);
        check("t6_level2", 32'(level), 32'd2);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_level", 32'(level), 32'd0);
        check("t6_async_pc",    32'(rom_address), 32'd0);
        out_ready = 1'b1;
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        check("t6_restart_idle", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("t6_restart_valid", 32'(out_valid), 32'd1);
        check("t6_restart_addr",  32'(out_addr), 32'd0);
        check("t6_restart_data",  32'(out_data), 32'h08);

        // Randomized traffic in phases of differing backpressure
        for (int c = 0; c < 3000; c++) begin
            int phase;
            @(negedge clock);
            phase      = (c / 250) % 3;
            fetch_en   = ($urandom_range(0, 7) != 0);
            case (phase)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) == 0);
                default: out_ready = ($urandom_range(0, 1) == 0);
            endcase
            jump_valid = ($urandom_range(0, 49) == 0);
            jump_addr  = 5'($urandom);
        end
        @(negedge clock);
        jump_valid = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
